mux8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 8-input, 1-output data multiplexer between eight requesters. It accepts one request bit per input lane, grants exactly one lane at a time, and drives the multiplexer's 3-bit select. A grant is held while its owner keeps requesting, bounded by a hold limit, after which ownership rotates fairly. It sits between the requesting agents and the mux select port.

---
 rtl/mux8_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of an 8:1 data multiplexer.
// Grants are held while requested, bounded by MAX_HOLD, with same-edge handover.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] select,
  output logic       grant_valid
);

  localparam int              HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
  localparam logic            LIMITED  = (MAX_HOLD != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      owner_q, owner_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [7:0]      grant_q, grant_d;
  logic            valid_q, valid_d;

  logic [7:0]      others_s;
  logic            release_s;
  logic            expire_s;
  logic [3:0]      pick_idle_s;
  logic [3:0]      pick_next_s;

  // Returns {found, index} of the first set bit scanning from p upward, wrapping mod 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic       found;
    logic [2:0] win;
    logic [2:0] idx;
    found = 1'b0;
    win   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = p + 3'(k);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  // Arbitration: next owner, pointer, hold count and registered outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    others_s    = req & ~(8'b1 << owner_q);
    release_s   = ~req[owner_q];
    expire_s    = LIMITED && (hold_q == HOLD_MAX) && req[owner_q] && (|others_s);
    pick_idle_s = rr_pick(req, ptr_q);
    // The old owner is masked out, so on expiry it cannot win its own handover.
    pick_next_s = rr_pick(others_s, owner_q + 3'd1);

    case (state_q)
      IDLE: begin
        if (pick_idle_s[3]) begin
          owner_d = pick_idle_s[2:0];
          hold_d  = HW'(1);
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_s || expire_s) begin
          ptr_d = owner_q + 3'd1;
          if (pick_next_s[3]) begin
            owner_d = pick_next_s[2:0];
            hold_d  = HW'(1);
            state_d = GRANT;
          end else begin
            hold_d  = {HW{1'b0}};
            state_d = IDLE;
          end
        end else if (LIMITED && (hold_q != HOLD_MAX)) begin
          hold_d = hold_q + HW'(1);
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == GRANT) begin
      grant_d = 8'b1 << owner_d;
      valid_d = 1'b1;
    end else begin
      grant_d = 8'h00;
      valid_d = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      owner_q <= 3'd0;
      hold_q  <= {HW{1'b0}};
      grant_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  // owner_q keeps the last owner after release, so select never glitches.
  assign grant       = grant_q;
  assign select      = owner_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized and directed bench for mux8_rr_arbiter against a behavioural model.
module tb_mux8_rr_arbiter;

  localparam int MH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] select;
  logic       grant_valid;

  int n_vec;
  int n_err;

  // model state: owner -1 means nobody holds the mux
  int m_owner;
  int m_ptr;
  int m_hold;
  int m_sel;

  mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .select     (select),
    .grant_valid(grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_sel   = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic [7:0] others;
    int w;
    if (m_owner < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 1;
        m_sel   = w;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner] || (MH != 0 && m_hold == MH && others != 8'h00)) begin
        m_ptr = (m_owner + 1) % 8;
        w = pick(others, m_ptr);
        if (w >= 0) begin
          m_owner = w;
          m_hold  = 1;
          m_sel   = w;
        end else begin
          m_owner = -1;
        end
      end else if (MH != 0 && m_hold < MH) begin
        m_hold++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    chk({tag, ".grant"}, grant, eg);
    chk({tag, ".select"}, {5'd0, select}, 8'(m_sel));
    chk({tag, ".valid"}, {7'd0, grant_valid}, {7'd0, m_owner >= 0});
  endtask

  // apply one req value across one rising edge, then compare
  task automatic cyc(input logic [7:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_model(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk({tag, ".rst_grant"}, grant, 8'h00);
    chk({tag, ".rst_select"}, {5'd0, select}, 8'h00);
    chk({tag, ".rst_valid"}, {7'd0, grant_valid}, 8'h00);
    #1 rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst = 1'b1;
    req = 8'h00;
    #13;
    chk("reset.grant", grant, 8'h00);
    chk("reset.select", {5'd0, select}, 8'h00);
    chk("reset.valid", {7'd0, grant_valid}, 8'h00);
    rst = 1'b0;

    // reset / first grant
    cyc(8'h00, "idle");
    cyc(8'h81, "first");
    chk("first_grant_const", grant, 8'h01);

    // round-robin handover
    cyc(8'h0D, "rr_hold");
    cyc(8'h0C, "rr_to2");
    chk("rr_to2_const", grant, 8'h04);
    cyc(8'h08, "rr_to3");
    chk("rr_to3_const", grant, 8'h08);
    cyc(8'h00, "rr_drop");
    chk("rr_drop_sel", {5'd0, select}, 8'h03);

    // hold limit: lane 5 held for exactly MH cycles, then lane 1
    for (int i = 0; i < MH; i++) cyc(8'h22, "hold5");
    chk("hold5_const", grant, 8'h20);
    cyc(8'h22, "expire_to1");
    chk("expire_to1_const", grant, 8'h02);
    cyc(8'h22, "hold1");
    cyc(8'h20, "back_to5");
    chk("back_to5_const", grant, 8'h20);

    // no contention at expiry
    cyc(8'h00, "drop5");
    for (int i = 0; i < 20; i++) cyc(8'h40, "solo6");
    chk("solo6_const", grant, 8'h40);
    cyc(8'h44, "to2");
    chk("to2_const", grant, 8'h04);

    // asynchronous reset mid-grant
    cyc(8'h00, "drop2");
    cyc(8'h10, "own4");
    chk("own4_const", grant, 8'h10);
    async_reset("mid");
    cyc(8'hFF, "after_rst");
    chk("after_rst_const", grant, 8'h01);

    // wrap-around from lane 7 to lane 0
    cyc(8'h80, "own7");
    cyc(8'h01, "wrap");
    chk("wrap_const", grant, 8'h01);

    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      logic [7:0] r;
      case ($urandom_range(0, 3))
        0:       r = 8'($urandom);
        1:       r = 8'($urandom) & 8'($urandom);
        2:       r = (m_owner >= 0 && $urandom_range(0, 1) == 1) ? (8'h01 << m_owner) | (8'($urandom) & 8'($urandom) & 8'($urandom)) : 8'($urandom) & 8'($urandom) & 8'($urandom);
        default: r = 8'h01 << $urandom_range(0, 7);
      endcase
      cyc(r, "rand");
      if ($urandom_range(0, 99) == 0) async_reset("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
